stage_sequencer: RTL and testbench

- Multi-cycle sequencer for the RISC core: steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Skips stages the instruction does not need, using the decoded control signals from control_unit (MemRd, MemWr, regWr, pc_control).
- Issues the enables that advance the datapath: ir_we, pc_we, reg_we, and the memory requests.
- Handles ready handshakes with instruction and data memory, enforces a wait timeout, and counts retired instructions.

---
 rtl/stage_sequencer.sv | 161 ++++++++++++++++
 tb/tb_stage_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer that skips unneeded stages,
// drives datapath enables and memory requests, and counts retired instructions.
module stage_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic             regWr,
    input  logic [1:0]       pc_control,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic             ir_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [2:0]       stage,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] instr_count
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_ERROR     = 3'd7
    } state_t;

    state_t             state_reg, state_next;
    logic [WAIT_W-1:0]  wait_reg, wait_next;
    logic               mem_rd_reg, mem_wr_reg, reg_wr_reg;
    logic [1:0]         pc_sel_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               wait_expired;

    // The cycle that sees wait_reg == WAIT_LAST is the TIMEOUT-th waiting cycle.
    assign wait_expired = TIMEOUT_EN && (wait_reg == WAIT_LAST);

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                    wait_next  = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (mem_rd_reg && mem_wr_reg) begin
                    state_next = S_ERROR;
                end else if (mem_rd_reg || mem_wr_reg) begin
                    state_next = S_MEMORY;
                    wait_next  = '0;
                end else if (reg_wr_reg) begin
                    state_next = S_WRITEBACK;
                end else begin
                    pc_we = 1'b1;
                end
            end
            S_MEMORY: begin
                dmem_req  = 1'b1;
                mem_rd_en = mem_rd_reg;
                mem_wr_en = mem_wr_reg;
                if (dmem_ready) begin
                    if (mem_rd_reg && reg_wr_reg) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        pc_we = 1'b1;
                    end
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end else begin
                    wait_next = wait_reg + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
            end
            S_ERROR: begin
                state_next = S_ERROR;
            end
            default: begin
                state_next = S_ERROR;
            end
        endcase
        // Every retirement funnels through pc_we, so the next fetch decision lives here.
        if (pc_we) begin
            state_next = run ? S_FETCH : S_IDLE;
            wait_next  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            wait_reg   <= '0;
            mem_rd_reg <= 1'b0;
            mem_wr_reg <= 1'b0;
            reg_wr_reg <= 1'b0;
            pc_sel_reg <= 2'b00;
            count_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (state_reg == S_DECODE) begin
                mem_rd_reg <= MemRd;
                mem_wr_reg <= MemWr;
                reg_wr_reg <= regWr;
                pc_sel_reg <= pc_control;
            end
            if (pc_we) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign stage       = state_reg;
    assign busy        = (state_reg != S_IDLE) && (state_reg != S_ERROR);
    assign error       = (state_reg == S_ERROR);
    assign pc_sel      = pc_sel_reg;
    assign instr_count = count_reg;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized self-checking bench: a per-instruction trace model expands each instruction into
// the expected per-cycle outputs, and the DUT is compared against it every cycle.
module tb_stage_sequencer;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic             clock = 1'b0;
    logic             reset, run, MemRd, MemWr, regWr, imem_ready, dmem_ready;
    logic [1:0]       pc_control;
    logic             imem_req, dmem_req, mem_rd_en, mem_wr_en, ir_we, reg_we, pc_we, busy, error;
    logic [1:0]       pc_sel;
    logic [2:0]       stage;
    logic [CNT_W-1:0] instr_count;

    stage_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .run(run), .MemRd(MemRd), .MemWr(MemWr), .regWr(regWr),
        .pc_control(pc_control), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel), .stage(stage),
        .busy(busy), .error(error), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    logic [17:0] obs;
    assign obs = {stage, imem_req, dmem_req, mem_rd_en, mem_wr_en, ir_we, reg_we, pc_we,
                  busy, error, pc_sel, instr_count};

    typedef struct {
        logic       run_v, iready, dready, mrd, mwr, rwr;
        logic [1:0] pcc;
        logic [17:0] want;
    } ent_t;

    ent_t       q[$];
    logic [1:0] m_pcsel;
    logic [3:0] m_cnt;
    int         n_checks, n_errs, cyc;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] r2();
        return 2'($urandom_range(0, 3));
    endfunction

    function automatic logic [17:0] ex(input logic [2:0] st, input logic ireq, dreq, rde, wre,
                                       irw, rgw, pcw);
        logic b, er;
        b  = (st >= 3'd1) && (st <= 3'd5);
        er = (st == 3'd7);
        return {st, ireq, dreq, rde, wre, irw, rgw, pcw, b, er, m_pcsel, m_cnt};
    endfunction

    function automatic void push(input logic rv, ir, dr, mrd, mwr, rwr, input logic [1:0] pcc,
                                 input logic [17:0] w);
        ent_t t;
        t.run_v = rv; t.iready = ir; t.dready = dr;
        t.mrd = mrd; t.mwr = mwr; t.rwr = rwr; t.pcc = pcc; t.want = w;
        q.push_back(t);
    endfunction

    function automatic void push_idle(input logic rv);
        push(rv, rb(), rb(), rb(), rb(), rb(), r2(), ex(3'd0, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    function automatic void push_err(input int n);
        for (int i = 0; i < n; i++)
            push(rb(), rb(), rb(), rb(), rb(), rb(), r2(), ex(3'd7, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    function automatic void retire();
        m_cnt = m_cnt + 4'd1;
    endfunction

    // One instruction: iw/dw = ready-low cycles before imem/dmem ready; run_post applies from
    // the first MEMORY cycle (or the retiring cycle) on.
    function automatic void add_instr(input logic rd, wr, rw, input logic [1:0] pcc,
                                      input int iw, dw, input logic run_pre, run_post);
        for (int i = 0; i <= iw; i++)
            push(run_pre, i == iw, rb(), rb(), rb(), rb(), r2(),
                 ex(3'd1, 1, 0, 0, 0, i == iw, 0, 0));
        push(run_pre, rb(), rb(), rd, wr, rw, pcc, ex(3'd2, 0, 0, 0, 0, 0, 0, 0));
        m_pcsel = pcc;
        if (rd && wr) begin
            push(run_pre, rb(), rb(), rb(), rb(), rb(), r2(), ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
            push_err(3);
            return;
        end
        if (!rd && !wr && !rw) begin
            push(run_post, rb(), rb(), rb(), rb(), rb(), r2(), ex(3'd3, 0, 0, 0, 0, 0, 0, 1));
            retire();
            return;
        end
        push(run_pre, rb(), rb(), rb(), rb(), rb(), r2(), ex(3'd3, 0, 0, 0, 0, 0, 0, 0));
        if (rd || wr) begin
            for (int j = 0; j <= dw; j++) begin
                logic fin;
                fin = (j == dw) && !(rd && rw);
                push(run_post, rb(), j == dw, rb(), rb(), rb(), r2(),
                     ex(3'd4, 0, 1, rd, wr, 0, 0, fin));
                if (fin) retire();
            end
            if (!(rd && rw)) return;
        end
        push(run_post, rb(), rb(), rb(), rb(), rb(), r2(), ex(3'd5, 0, 0, 0, 0, 0, 1, 1));
        retire();
    endfunction

    task automatic apply(input ent_t e);
        run = e.run_v; imem_ready = e.iready; dmem_ready = e.dready;
        MemRd = e.mrd; MemWr = e.mwr; regWr = e.rwr; pc_control = e.pcc;
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; MemRd = 0; MemWr = 0; regWr = 0; pc_control = 0;
        imem_ready = 0; dmem_ready = 0; m_pcsel = 0; m_cnt = 0;
        repeat (3) begin
            @(negedge clock); run = 1'b1; imem_ready = 1'b1; #1;
            n_checks++; cyc++;
            if (obs !== 18'd0) begin
                n_errs++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, obs, 18'd0);
            end
        end
        @(negedge clock); run = 1'b0; reset = 1'b1; #1;
        n_checks++; cyc++;
        if (obs !== 18'd0) begin
            n_errs++; $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obs, 18'd0);
        end
    endtask

    task automatic test_directed();
        push_idle(1);
        add_instr(0, 0, 1, 2'b01, 0, 0, 1, 1);   // ADD
        add_instr(1, 0, 1, 2'b00, 0, 3, 1, 1);   // LW, dmem late by 3
        add_instr(0, 1, 0, 2'b11, 0, 0, 1, 1);   // SW
        add_instr(0, 0, 0, 2'b10, 2, 0, 1, 0);   // branch, run dropped
        push_idle(0);
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL directed cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
    endtask

    task automatic test_random();
        logic idle, rd, wr, rp;
        idle = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (idle) begin
                repeat ($urandom_range(0, 2)) push_idle(0);
                push_idle(1);
            end
            rd = rb();
            wr = rd ? 1'b0 : rb();
            rp = (n == 39) ? 1'b0 : rb();
            add_instr(rd, wr, rb(), r2(), $urandom_range(0, 6), $urandom_range(0, 6), rb(), rp);
            idle = !rp;
        end
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
    endtask

    task automatic test_timeout();
        push_idle(1);
        for (int i = 0; i < TIMEOUT; i++)
            push(1, 0, rb(), rb(), rb(), rb(), r2(), ex(3'd1, 1, 0, 0, 0, 0, 0, 0));
        push_err(4);
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL timeout cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
        @(negedge clock); reset = 1'b0; run = 1'b0; #1;
        m_cnt = 0; m_pcsel = 0;
        n_checks++; cyc++;
        if (obs !== 18'd0) begin
            n_errs++; $display("FAIL timeout_recover cyc=%0d got=%h want=%h", cyc, obs, 18'd0);
        end
        @(negedge clock); reset = 1'b1;
        // Ready arriving in the last allowed waiting cycle must still win.
        push_idle(1);
        add_instr(1, 0, 1, 2'b10, TIMEOUT - 1, TIMEOUT - 1, 1, 0);
        push_idle(0);
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL ready_at_limit cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
    endtask

    task automatic test_conflict();
        push_idle(1);
        add_instr(1, 1, rb(), 2'b01, 2, 0, 1, 1);
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL conflict cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
        @(negedge clock); reset = 1'b0; run = 1'b0; #1;
        m_cnt = 0; m_pcsel = 0;
        n_checks++; cyc++;
        if (obs !== 18'd0) begin
            n_errs++; $display("FAIL conflict_reset cyc=%0d got=%h want=%h", cyc, obs, 18'd0);
        end
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_run_drop();
        push_idle(1);
        add_instr(1, 0, 1, 2'b11, 1, 3, 1, 0);
        push_idle(0);
        push_idle(0);
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL run_drop cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
        n_checks++;
        if (stage !== 3'd0) begin
            n_errs++; $display("FAIL run_drop_idle got=%0d want=0", stage);
        end
    endtask

    task automatic test_async_reset();
        int mem_seen;
        mem_seen = 0;
        push_idle(1);
        add_instr(0, 1, 0, 2'b01, 0, 8, 1, 1);
        while (q.size() > 0 && mem_seen < 2) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL async_pre cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
            if (e.want[17:15] == 3'd4) mem_seen++;
        end
        q.delete();
        #2 reset = 1'b0; run = 1'b0;
        #1;
        m_cnt = 0; m_pcsel = 0;
        n_checks++;
        if (obs !== 18'd0) begin
            n_errs++; $display("FAIL async_reset got=%h want=%h", obs, 18'd0);
        end
        n_checks++;
        if (instr_count !== 4'd0) begin
            n_errs++; $display("FAIL async_count got=%0d want=0", instr_count);
        end
        @(negedge clock); #1;
        n_checks++;
        if (obs !== 18'd0) begin
            n_errs++; $display("FAIL async_held got=%h want=%h", obs, 18'd0);
        end
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        push_idle(1);
        for (int i = 0; i < 15; i++) add_instr(0, 0, 0, r2(), 0, 0, 1, 1);
        add_instr(0, 0, 0, r2(), 0, 0, 1, 0);
        push_idle(0);
        while (q.size() > 0) begin
            ent_t e;
            e = q.pop_front();
            @(negedge clock); apply(e); #1;
            n_checks++; cyc++;
            if (obs !== e.want) begin
                n_errs++; $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, obs, e.want);
            end
        end
        n_checks++;
        if (instr_count !== 4'd0) begin
            n_errs++; $display("FAIL wrap_count got=%0d want=0", instr_count);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errs = 0; cyc = 0;
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_conflict();
        test_run_drop();
        test_async_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
